// File: rtl/cam_match_scanner.sv
// cam_match_scanner
// Snapshots a CAM match vector on start and streams the address of every
// matching cell, lowest first, over a valid/ready handshake. One chunk of
// cells is examined per scan cycle. A done pulse marks normal completion,
// and match_count holds the number of addresses handed off.
module cam_match_scanner #(
    parameter  int CELL_QUANT = 512,
    parameter  int CHUNK      = 32,
    localparam int ADDR_W     = $clog2(CELL_QUANT + 1),
    localparam int NCHUNK     = CELL_QUANT / CHUNK
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CELL_QUANT-1:0] tags,
    output logic                  busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_W-1:0]     m_addr,
    output logic                  done,
    output logic [ADDR_W:0]       match_count
);

    localparam int IDX_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int P_W   = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                  state_q;
    logic [CELL_QUANT-1:0]   shadow_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    m_valid_q;
    logic [ADDR_W-1:0]       m_addr_q;
    logic                    done_q;
    logic [ADDR_W:0]         match_count_q;

    // Shadow register viewed as an array of chunks for the per-cycle scan.
    logic [CHUNK-1:0]        chunk_w [NCHUNK];
    logic [CHUNK-1:0]        cur_chunk;
    logic                    hit_any;
    logic [P_W-1:0]          hit_p;
    logic [ADDR_W-1:0]       hit_addr;
    logic [CELL_QUANT-1:0]   clr_mask;

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
        assign chunk_w[gi] = shadow_q[gi*CHUNK +: CHUNK];
    end

    assign cur_chunk = chunk_w[idx_q];
    assign hit_any   = |cur_chunk;

    // Priority encoder: index of the lowest set bit in the current chunk.
    always_comb begin
        hit_p = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (cur_chunk[i]) begin
                hit_p = P_W'(i);
            end
        end
    end

    assign hit_addr = ADDR_W'(idx_q) * ADDR_W'(CHUNK) + ADDR_W'(hit_p);
    // One-hot mask used to retire the emitted cell from the shadow copy.
    assign clr_mask = {{(CELL_QUANT-1){1'b0}}, 1'b1} << hit_addr;

    // Scan FSM with registered handshake, done and count outputs.
    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shadow_q      <= '0;
            idx_q         <= '0;
            m_valid_q     <= 1'b0;
            m_addr_q      <= '0;
            done_q        <= 1'b0;
            match_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_q      <= tags;
                        idx_q         <= '0;
                        match_count_q <= '0;
                        state_q       <= SCAN;
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                    end else if (hit_any) begin
                        // idx stays put so the remainder of this chunk is rescanned.
                        m_addr_q  <= hit_addr;
                        m_valid_q <= 1'b1;
                        shadow_q  <= shadow_q & ~clr_mask;
                        state_q   <= EMIT;
                    end else if (idx_q == IDX_W'(NCHUNK - 1)) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                EMIT: begin
                    if (m_valid_q && m_ready) begin
                        m_valid_q     <= 1'b0;
                        match_count_q <= match_count_q + 1'b1;
                        state_q       <= SCAN;
                    end
                    // A coincident handshake above is still counted.
                    if (abort) begin
                        m_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != IDLE);
    assign m_valid     = m_valid_q;
    assign m_addr      = m_addr_q;
    assign done        = done_q;
    assign match_count = match_count_q;

endmodule

// File: tb/tb_cam_match_scanner.sv
// Directed testbench for cam_match_scanner with default parameters.
module tb_cam_match_scanner;

    localparam int CELL_QUANT = 512;
    localparam int ADDR_W     = 10;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic [CELL_QUANT-1:0] tags;
    logic                  busy;
    logic                  m_valid;
    logic                  m_ready;
    logic [ADDR_W-1:0]     m_addr;
    logic                  done;
    logic [ADDR_W:0]       match_count;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int got_q[$];

    cam_match_scanner #(.CELL_QUANT(512), .CHUNK(32)) dut (
        .CLK100MHZ   (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .tags        (tags),
        .busy        (busy),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_addr      (m_addr),
        .done        (done),
        .match_count (match_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts a scan at a negedge and follows it to done with m_ready high.
    // cycles counts clock edges after the start edge until done is seen.
    // With tamper set, tags is flooded and start held one extra cycle.
    task automatic run_scan(input logic [CELL_QUANT-1:0] t, input bit tamper,
                            output int cycles, output int busy_cycles,
                            output int valid_cycles);
        got_q.delete();
        tags    = t;
        start   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        if (tamper) tags = '1;
        else start = 1'b0;
        cycles = 0; busy_cycles = 0; valid_cycles = 0;
        while (!done && cycles < 400) begin
            if (busy) busy_cycles++;
            if (m_valid) begin
                valid_cycles++;
                if (m_ready) begin
                    got_q.push_back(int'(m_addr));
                    $display("xfer addr=%0d count_before=%0d t=%0t", m_addr, match_count, $time);
                end
            end
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b0; tags = '0;
        #12;
        total_cnt++;
        if ({busy, m_valid, m_addr, done, match_count} !== '0) begin
            $display("FAIL reset_outputs got=%h want=0", {busy, m_valid, m_addr, done, match_count});
        end else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle_busy got=%b want=0", busy);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int cyc, bcyc, vcyc;
        run_scan('0, 1'b0, cyc, bcyc, vcyc);
        total_cnt++;
        if (cyc !== 16) $display("FAIL zero_cycles got=%0d want=16", cyc);
        else pass_cnt++;
        total_cnt++;
        if (bcyc !== 16) $display("FAIL zero_busy_cycles got=%0d want=16", bcyc);
        else pass_cnt++;
        total_cnt++;
        if (vcyc !== 0) $display("FAIL zero_valid_cycles got=%0d want=0", vcyc);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 11'd0) $display("FAIL zero_count got=%0d want=0", match_count);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL zero_done_width got=%b want=0", done);
        else pass_cnt++;
    endtask

    task automatic test_sparse();
        int cyc, bcyc, vcyc;
        int exp_a[3] = '{3, 40, 511};
        logic [CELL_QUANT-1:0] t;
        t = '0; t[3] = 1'b1; t[40] = 1'b1; t[511] = 1'b1;
        run_scan(t, 1'b0, cyc, bcyc, vcyc);
        total_cnt++;
        if (got_q.size() !== 3) $display("FAIL sparse_xfers got=%0d want=3", got_q.size());
        else pass_cnt++;
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_a[i]) $display("FAIL sparse_addr%0d got=%0d want=%0d", i, got_q[i], exp_a[i]);
            else pass_cnt++;
        end
        total_cnt++;
        if (cyc !== 22) $display("FAIL sparse_cycles got=%0d want=22", cyc);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 11'd3) $display("FAIL sparse_count got=%0d want=3", match_count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        tags = '0; tags[5] = 1'b1; m_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!m_valid && n < 50) begin @(negedge clk); n++; end
        total_cnt++;
        if (n >= 50) $display("FAIL bp_valid_timeout got=%0d want<50", n);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_addr !== 10'd5)
                $display("FAIL bp_hold%0d got=%b/%0d want=1/5", i, m_valid, m_addr);
            else pass_cnt++;
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0 || match_count !== 11'd1)
            $display("FAIL bp_xfer got=%b/%0d want=0/1", m_valid, match_count);
        else pass_cnt++;
        n = 0;
        while (!done && n < 50) begin @(negedge clk); n++; end
        total_cnt++;
        if (done !== 1'b1 || match_count !== 11'd1)
            $display("FAIL bp_done got=%b/%0d want=1/1", done, match_count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_dense();
        int cyc, bcyc, vcyc, bad;
        logic [CELL_QUANT-1:0] t;
        t = '0; t[31:0] = '1;
        run_scan(t, 1'b0, cyc, bcyc, vcyc);
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== i) bad++;
        total_cnt++;
        if (got_q.size() !== 32 || bad !== 0)
            $display("FAIL dense_seq got=%0d xfers/%0d bad want=32/0", got_q.size(), bad);
        else pass_cnt++;
        total_cnt++;
        if (cyc !== 80) $display("FAIL dense_cycles got=%0d want=80", cyc);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 11'd32) $display("FAIL dense_count got=%0d want=32", match_count);
        else pass_cnt++;
        @(negedge clk);
    endtask

    // Abort during EMIT for address 20; ready_at_abort selects whether the
    // handshake coincides with the abort.
    task automatic test_abort(input bit ready_at_abort);
        int n, dones;
        logic [ADDR_W:0] exp_cnt;
        exp_cnt = ready_at_abort ? 11'd2 : 11'd1;
        tags = '0; tags[10] = 1'b1; tags[20] = 1'b1; m_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(m_valid && m_addr == 10'd20) && n < 100) begin @(negedge clk); n++; end
        total_cnt++;
        if (n >= 100) $display("FAIL abort_wait%0d got=%0d want<100", ready_at_abort, n);
        else pass_cnt++;
        m_ready = ready_at_abort;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        m_ready = 1'b1;
        total_cnt++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            $display("FAIL abort_state%0d got=v%b b%b d%b want=v0 b0 d0", ready_at_abort, m_valid, busy, done);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== exp_cnt)
            $display("FAIL abort_count%0d got=%0d want=%0d", ready_at_abort, match_count, exp_cnt);
        else pass_cnt++;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) dones++;
            @(negedge clk);
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL abort_quiet%0d got=%0d want=0", ready_at_abort, dones);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int n;
        tags = '0; tags[10] = 1'b1; tags[20] = 1'b1; m_ready = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!m_valid && n < 100) begin @(negedge clk); n++; end
        #1 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, m_valid, m_addr, done, match_count} !== '0)
            $display("FAIL reset_mid got=%h want=0", {busy, m_valid, m_addr, done, match_count});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_isolation();
        int cyc, bcyc, vcyc;
        logic [CELL_QUANT-1:0] t;
        t = '0; t[7] = 1'b1;
        run_scan(t, 1'b1, cyc, bcyc, vcyc);
        tags = '0;
        total_cnt++;
        if (got_q.size() !== 1) $display("FAIL iso_xfers got=%0d want=1", got_q.size());
        else pass_cnt++;
        total_cnt++;
        if (got_q.size() > 0 && got_q[0] !== 7) $display("FAIL iso_addr got=%0d want=7", got_q[0]);
        else pass_cnt++;
        total_cnt++;
        if (match_count !== 11'd1 || cyc !== 18)
            $display("FAIL iso_done got=cnt%0d cyc%0d want=cnt1 cyc18", match_count, cyc);
        else pass_cnt++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_sparse();
        test_backpressure();
        test_dense();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_mid();
        test_isolation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cam_match_scanner.md
# cam_match_scanner

Reads back the result of a CAM compare pass. It captures the CAM `tags` match vector on `start` and streams the address of every matching cell, lowest address first, over a valid/ready handshake. When the scan finishes it pulses `done` and reports the total match count. The block sits between the CAM array's tag outputs and the associative-processor sequencer, which consumes match addresses to drive follow-up reads and writes.

## Interface
- `CELL_QUANT`, 512: number of CAM cells, equal to the width of `tags`. Must be a multiple of `CHUNK`.
- `CHUNK`, 32: cells examined per scan cycle.
- `ADDR_W`, derived, clogb2(`CELL_QUANT`) with clogb2(n) = bit count of n (512 -> 10): width of `m_addr`. Same as the CAM `addr_in` width.
- `NCHUNK`, derived, `CELL_QUANT`/`CHUNK`.
- `CLK100MHZ`  in  1  sole clock, all state on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  capture `tags` and begin a scan. Honoured only when `busy`=0.
- `abort`  in  1  cancel an in-progress scan. Honoured only when `busy`=1.
- `tags`  in  `CELL_QUANT`  CAM match vector; bit g is cell g.
- `busy`  out  1  high while the FSM is not IDLE.
- `m_valid`  out  1  a match address is presented.
- `m_ready`  in  1  consumer accepts `m_addr`.
- `m_addr`  out  `ADDR_W`  address of the matching cell.
- `done`  out  1  one-cycle pulse at normal scan completion.
- `match_count`  out  `ADDR_W`+1  number of addresses handed off in the current or last scan.

## Operation
- Registers:
  - `shadow[CELL_QUANT]`
  - chunk index `idx` (0..`NCHUNK`-1)
  - FSM state: IDLE, SCAN, EMIT
- Reset (async, `rst_n`=0): state IDLE, `shadow`=0, `idx`=0. All outputs 0: `busy`, `m_valid`, `m_addr`, `done`, `match_count`.
- IDLE with `start`=1:
  - `shadow` <= `tags`, `idx` <= 0, `match_count` <= 0, state <= SCAN.
  - `tags` is sampled only on this edge; later changes to `tags` are ignored.
- SCAN (one chunk per edge). Let `c` = `shadow[idx*CHUNK +: CHUNK]`.
  - `c`≠0: let p = index of the lowest set bit of `c`. Then `m_addr` <= `idx*CHUNK+p`, `m_valid` <= 1, `shadow` bit cleared, state <= EMIT. `idx` is unchanged so the rest of the chunk is rescanned.
  - `c`=0 and `idx`<`NCHUNK`-1: `idx` <= `idx`+1.
  - `c`=0 and `idx`=`NCHUNK`-1: state <= IDLE, `done` <= 1.
- EMIT:
  - `m_valid` && `m_ready`: `m_valid` <= 0, `match_count` += 1, state <= SCAN.
  - Otherwise hold. `m_addr` and `m_valid` must stay stable until the handshake.
- Addresses are emitted in strictly ascending order, with no duplicates and no omissions.
- `abort` while `busy`:
  - Next edge: state IDLE, `m_valid`=0, no `done` pulse.
  - `match_count` keeps its partial value.
  - If `abort` coincides with an EMIT handshake, the handshake completes and is counted; the FSM still goes to IDLE.
- `start` while `busy`: ignored. `abort` while IDLE: ignored. `m_ready` while `m_valid`=0: ignored.
- `done` is high for exactly the first cycle back in IDLE. A `start` in that cycle is accepted.

## Timing
- `busy` is combinational from state (high in SCAN/EMIT) and rises the cycle after the `start` edge.
- An empty chunk costs 1 cycle.
- Each match costs:
  - 1 SCAN cycle (registers the address), then
  - at least 1 EMIT cycle. With `m_ready` held high, EMIT lasts exactly 1 cycle, giving a 2-cycle throughput per match.
- Total cycles from `start` edge to `done` with `m_ready`=1 and M matches: `NCHUNK` + 2M. For the defaults, zero matches gives 16 cycles.
- `m_valid` first rises 1 cycle after the SCAN edge that finds the match.
- Reset mid-scan aborts immediately and asynchronously. The pending `m_valid` is dropped.

## Test plan
- Zero matches: `tags`=0, pulse `start` -> `busy` high 16 cycles, `done` pulse on cycle 17, `match_count`=0, `m_valid` never asserted.
- Sparse matches: `tags` bits {3,40,511}, `m_ready`=1 -> `m_addr` 3, 40, 511 in order, one transfer each; `match_count`=3; `done` 22 cycles after `start`.
- Backpressure: bit 5 only, `m_ready` low for 4 cycles after `m_valid` rises -> `m_addr`=5 and `m_valid` stable for all 4 cycles; one transfer on the `m_ready` cycle; `done` follows with `match_count`=1.
- Dense chunk: `tags` bits 0..31 set, `m_ready`=1 -> addresses 0..31 consecutively at 2 cycles each; `match_count`=32; `done` at 16+64 cycles.
- Abort and reset:
  - Bits {10,20}: assert `abort` during the EMIT for 20 after 10 was accepted -> `m_valid`=0 and `busy`=0 next cycle, no `done`, `match_count`=1.
  - Repeat with `rst_n` low mid-scan -> all outputs 0 immediately.
- Tag isolation: after `start` with bit 7, set `tags` to all ones -> only address 7 is emitted, `match_count`=1. A second `start` while `busy` is ignored.
